// File: rtl/fractal_sync_rf_sched_if.sv
// fractal_sync_rf_sched_if: requester/response handshake bundle
// of the RF scheduler; master = requesters, slave = scheduler.
interface fractal_sync_rf_sched_if #(
    parameter  int unsigned N_REQ       = 4,
    parameter  int unsigned LEVEL_WIDTH = 1,
    parameter  int unsigned ID_WIDTH    = 1,
    parameter  int unsigned SD_WIDTH    = 2,
    localparam int unsigned IDX_W       = $clog2(N_REQ)
);
    logic [N_REQ-1:0]                  req_valid_i;
    logic [N_REQ-1:0]                  req_ready_o;
    logic [N_REQ-1:0][LEVEL_WIDTH-1:0] req_level_i;
    logic [N_REQ-1:0][ID_WIDTH-1:0]    req_id_i;
    logic [N_REQ-1:0]                  req_local_i;
    logic [N_REQ-1:0][SD_WIDTH-1:0]    req_sd_i;
    logic                              rsp_valid_o;
    logic                              rsp_ready_i;
    logic [IDX_W-1:0]                  rsp_idx_o;
    logic                              rsp_present_o;
    logic [SD_WIDTH-1:0]               rsp_sd_o;
    logic                              rsp_err_o;

    modport master (
        output req_valid_i, req_level_i, req_id_i,
        output req_local_i, req_sd_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_idx_o,
        input  rsp_present_o, rsp_sd_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_level_i, req_id_i,
        input  req_local_i, req_sd_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_idx_o,
        output rsp_present_o, rsp_sd_o, rsp_err_o
    );
endinterface

// File: rtl/fractal_sync_rf_sched.sv
// fractal_sync_rf_sched: round-robin scheduler sharing one RF check port.
// Optional retry FIFO for bypassed checks: FRACTAL_SYNC_RF_SCHED_RETRY_EN.
package fractal_sync_pkg;
    localparam int unsigned SD_WIDTH = 2;
endpackage

module fractal_sync_rf_sched #(
    parameter  int unsigned N_REQ       = 4,
    parameter  int unsigned LEVEL_WIDTH = 1,
    parameter  int unsigned ID_WIDTH    = 1,
    parameter  int unsigned RETRY_DEPTH = 2,
    localparam int unsigned SD_WIDTH    = fractal_sync_pkg::SD_WIDTH,
    localparam int unsigned IDX_W       = $clog2(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    fractal_sync_rf_sched_if.slave bus,
    output logic [LEVEL_WIDTH-1:0] level_o,
    output logic [ID_WIDTH-1:0]    id_o,
    output logic                   check_local_o,
    output logic                   check_remote_o,
    output logic [SD_WIDTH-1:0]    sd_local_o,
    input  logic                   present_local_i,
    input  logic                   present_remote_i,
    input  logic                   id_err_i,
    input  logic                   sig_err_i,
    input  logic                   bypass_local_i,
    input  logic                   bypass_remote_i,
    input  logic                   ignore_local_i,
    input  logic                   ignore_remote_i,
    input  logic [SD_WIDTH-1:0]    sd_local_i,
    output logic                   busy_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    typedef struct packed {
        logic [IDX_W-1:0]       idx;
        logic                   is_local;
        logic [LEVEL_WIDTH-1:0] level;
        logic [ID_WIDTH-1:0]    id;
        logic [SD_WIDTH-1:0]    sd;
    } txn_t;

    function automatic logic [IDX_W-1:0] wrap_add(
        input logic [IDX_W-1:0] a,
        input int unsigned      b
    );
        int unsigned s;
        s = 32'(a) + b;
        if (s >= N_REQ) s = s - N_REQ;
        return IDX_W'(s);
    endfunction

    state_e              state_q, state_d;
    txn_t                iss_q, iss_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic                chk_loc_q, chk_loc_d;
    logic                chk_rem_q, chk_rem_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0]    rsp_idx_q, rsp_idx_d;
    logic                rsp_present_q, rsp_present_d;
    logic                rsp_err_q, rsp_err_d;
    logic [SD_WIDTH-1:0] rsp_sd_q, rsp_sd_d;

    logic             gnt_vld;
    logic [IDX_W-1:0] gnt_idx;
    logic             fifo_empty;
    logic             byp, ign;

`ifdef FRACTAL_SYNC_RF_SCHED_RETRY_EN
    localparam int unsigned PTR_W =
        (RETRY_DEPTH > 1) ? $clog2(RETRY_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RETRY_DEPTH + 1);

    txn_t             fifo_q [RETRY_DEPTH];
    txn_t             fifo_d [RETRY_DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fifo_full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RETRY_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_W'(RETRY_DEPTH));
`else
    assign fifo_empty = 1'b1;
`endif

    // Lowest offset from rr_q wins, so scan from the far end and overwrite.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (bus.req_valid_i[wrap_add(rr_q, unsigned'(i))]) begin
                gnt_vld = 1'b1;
                gnt_idx = wrap_add(rr_q, unsigned'(i));
            end
        end
    end

    assign bus.req_ready_o =
        (rst_ni && state_q == IDLE && fifo_empty && gnt_vld)
        ? (N_REQ'(1) << gnt_idx) : '0;

    assign byp = iss_q.is_local ? bypass_local_i : bypass_remote_i;
    assign ign = iss_q.is_local ? ignore_local_i : ignore_remote_i;

    always_comb begin
        state_d       = state_q;
        iss_d         = iss_q;
        rr_d          = rr_q;
        chk_loc_d     = 1'b0;
        chk_rem_d     = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_idx_d     = rsp_idx_q;
        rsp_present_d = rsp_present_q;
        rsp_err_d     = rsp_err_q;
        rsp_sd_d      = rsp_sd_q;
`ifdef FRACTAL_SYNC_RF_SCHED_RETRY_EN
        fifo_d = fifo_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef FRACTAL_SYNC_RF_SCHED_RETRY_EN
                if (!fifo_empty) begin
                    iss_d     = fifo_q[rd_q];
                    rd_d      = ptr_inc(rd_q);
                    cnt_d     = cnt_q - 1'b1;
                    state_d   = ISSUE;
                    chk_loc_d = fifo_q[rd_q].is_local;
                    chk_rem_d = !fifo_q[rd_q].is_local;
                end else
`endif
                if (gnt_vld) begin
                    iss_d.idx      = gnt_idx;
                    iss_d.is_local = bus.req_local_i[gnt_idx];
                    iss_d.level    = bus.req_level_i[gnt_idx];
                    iss_d.id       = bus.req_id_i[gnt_idx];
                    iss_d.sd       = bus.req_sd_i[gnt_idx];
                    rr_d           = wrap_add(gnt_idx, 1);
                    state_d        = ISSUE;
                    chk_loc_d      = bus.req_local_i[gnt_idx];
                    chk_rem_d      = !bus.req_local_i[gnt_idx];
                end
            end
            ISSUE: begin
                if (ign) begin
                    state_d = IDLE;
                end else if (byp) begin
`ifdef FRACTAL_SYNC_RF_SCHED_RETRY_EN
                    if (!fifo_full) begin
                        fifo_d[wr_q] = iss_q;
                        wr_d         = ptr_inc(wr_q);
                        cnt_d        = cnt_q + 1'b1;
                        state_d      = IDLE;
                    end else begin
                        chk_loc_d = iss_q.is_local;
                        chk_rem_d = !iss_q.is_local;
                    end
`else
                    chk_loc_d = iss_q.is_local;
                    chk_rem_d = !iss_q.is_local;
`endif
                end else begin
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_idx_d     = iss_q.idx;
                    rsp_present_d = iss_q.is_local ? present_local_i
                                                   : present_remote_i;
                    rsp_err_d     = iss_q.is_local ? id_err_i : sig_err_i;
                    rsp_sd_d      = iss_q.is_local ? sd_local_i : '0;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            iss_q         <= '0;
            rr_q          <= '0;
            chk_loc_q     <= 1'b0;
            chk_rem_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_idx_q     <= '0;
            rsp_present_q <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_sd_q      <= '0;
`ifdef FRACTAL_SYNC_RF_SCHED_RETRY_EN
            for (int i = 0; i < int'(RETRY_DEPTH); i++) fifo_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            iss_q         <= iss_d;
            rr_q          <= rr_d;
            chk_loc_q     <= chk_loc_d;
            chk_rem_q     <= chk_rem_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_idx_q     <= rsp_idx_d;
            rsp_present_q <= rsp_present_d;
            rsp_err_q     <= rsp_err_d;
            rsp_sd_q      <= rsp_sd_d;
`ifdef FRACTAL_SYNC_RF_SCHED_RETRY_EN
            fifo_q <= fifo_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
`endif
        end
    end

    assign level_o           = iss_q.level;
    assign id_o              = iss_q.id;
    assign sd_local_o        = iss_q.sd;
    assign check_local_o     = chk_loc_q;
    assign check_remote_o    = chk_rem_q;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_idx_o     = rsp_idx_q;
    assign bus.rsp_present_o = rsp_present_q;
    assign bus.rsp_err_o     = rsp_err_q;
    assign bus.rsp_sd_o      = rsp_sd_q;
    assign busy_o            = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fractal_sync_rf_sched.sv
// tb_fractal_sync_rf_sched: random requesters and RF verdicts checked
// against a transaction-level reference model of the scheduler.
module tb_fractal_sync_rf_sched;

    localparam int N     = 4;
    localparam int LW    = 1;
    localparam int IW    = 1;
    localparam int SDW   = fractal_sync_pkg::SD_WIDTH;
    localparam int DEPTH = 2;
`ifdef FRACTAL_SYNC_RF_SCHED_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fractal_sync_rf_sched_if #(
        .N_REQ(N), .LEVEL_WIDTH(LW), .ID_WIDTH(IW), .SD_WIDTH(SDW)
    ) bus ();

    logic [LW-1:0]  level_o;
    logic [IW-1:0]  id_o;
    logic           check_local_o, check_remote_o;
    logic [SDW-1:0] sd_local_o;
    logic           pres_l, pres_r, id_err, sig_err;
    logic           byp_l, byp_r, ign_l, ign_r;
    logic [SDW-1:0] sd_in;
    logic           busy_o;

    fractal_sync_rf_sched #(
        .N_REQ(N), .LEVEL_WIDTH(LW), .ID_WIDTH(IW), .RETRY_DEPTH(DEPTH)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .bus              (bus),
        .level_o          (level_o),
        .id_o             (id_o),
        .check_local_o    (check_local_o),
        .check_remote_o   (check_remote_o),
        .sd_local_o       (sd_local_o),
        .present_local_i  (pres_l),
        .present_remote_i (pres_r),
        .id_err_i         (id_err),
        .sig_err_i        (sig_err),
        .bypass_local_i   (byp_l),
        .bypass_remote_i  (byp_r),
        .ignore_local_i   (ign_l),
        .ignore_remote_i  (ign_r),
        .sd_local_i       (sd_in),
        .busy_o           (busy_o)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int idx;
        bit loc;
        int lvl;
        int id;
        int sd;
    } txn_t;

    // Model: phase 0 = waiting, 1 = checking, 2 = responding
    int   ph;
    txn_t cur;
    txn_t rq[$];
    int   rr;
    int   e_idx, e_sd;
    bit   e_pres, e_err;

    bit pend[N];
    bit p_loc[N];
    int p_lvl[N], p_id[N], p_sd[N];

    function automatic int model_grant();
        for (int k = 0; k < N; k++)
            if (pend[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        ph = 0;
        cur = '{default: 0};
        rq.delete();
        rr = 0;
        e_idx = 0; e_sd = 0; e_pres = 0; e_err = 0;
    endtask

    task automatic model_step();
        int g;
        bit vb, vi;
        case (ph)
            0: begin
                if (RETRY && rq.size() > 0) begin
                    cur = rq.pop_front();
                    ph = 1;
                end else begin
                    g = model_grant();
                    if (g >= 0) begin
                        cur = '{g, p_loc[g], p_lvl[g], p_id[g], p_sd[g]};
                        pend[g] = 1'b0;
                        rr = (g + 1) % N;
                        ph = 1;
                    end
                end
            end
            1: begin
                vb = cur.loc ? byp_l : byp_r;
                vi = cur.loc ? ign_l : ign_r;
                if (vi) ph = 0;
                else if (vb) begin
                    if (RETRY && rq.size() < DEPTH) begin
                        rq.push_back(cur);
                        ph = 0;
                    end
                end else begin
                    e_idx  = cur.idx;
                    e_pres = cur.loc ? pres_l : pres_r;
                    e_err  = cur.loc ? id_err : sig_err;
                    e_sd   = cur.loc ? int'(sd_in) : 0;
                    ph = 2;
                end
            end
            default: if (bus.rsp_ready_i) ph = 0;
        endcase
    endtask

    function automatic int exp_ready();
        int g;
        g = model_grant();
        if (ph == 0 && (!RETRY || rq.size() == 0) && g >= 0) return 1 << g;
        return 0;
    endfunction

    task automatic check_outputs();
        chk("check_local", check_local_o, ph == 1 && cur.loc);
        chk("check_remote", check_remote_o, ph == 1 && !cur.loc);
        chk("level_o", level_o, cur.lvl);
        chk("id_o", id_o, cur.id);
        chk("sd_local_o", sd_local_o, cur.sd);
        chk("rsp_valid", bus.rsp_valid_o, ph == 2);
        chk("busy", busy_o, ph != 0 || rq.size() > 0);
        if (ph == 2) begin
            chk("rsp_idx", bus.rsp_idx_o, e_idx);
            chk("rsp_present", bus.rsp_present_o, e_pres);
            chk("rsp_err", bus.rsp_err_o, e_err);
            chk("rsp_sd", bus.rsp_sd_o, e_sd);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, bus.req_ready_o, 0);
        chk({tag, "_chk_l"}, check_local_o, 0);
        chk({tag, "_chk_r"}, check_remote_o, 0);
        chk({tag, "_level"}, level_o, 0);
        chk({tag, "_id"}, id_o, 0);
        chk({tag, "_sd"}, sd_local_o, 0);
        chk({tag, "_rsp_v"}, bus.rsp_valid_o, 0);
        chk({tag, "_rsp_idx"}, bus.rsp_idx_o, 0);
        chk({tag, "_rsp_p"}, bus.rsp_present_o, 0);
        chk({tag, "_rsp_sd"}, bus.rsp_sd_o, 0);
        chk({tag, "_rsp_e"}, bus.rsp_err_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
    endtask

    task automatic spawn(input int r);
        pend[r]  = 1'b1;
        p_loc[r] = 1'($urandom_range(0, 1));
        p_lvl[r] = $urandom_range(0, (1 << LW) - 1);
        p_id[r]  = $urandom_range(0, (1 << IW) - 1);
        p_sd[r]  = $urandom_range(0, (1 << SDW) - 1);
    endtask

    task automatic apply_reqs();
        for (int r = 0; r < N; r++) begin
            bus.req_valid_i[r] = pend[r];
            bus.req_local_i[r] = p_loc[r];
            bus.req_level_i[r] = LW'(p_lvl[r]);
            bus.req_id_i[r]    = IW'(p_id[r]);
            bus.req_sd_i[r]    = SDW'(p_sd[r]);
        end
    endtask

    task automatic drive(input int mode);
        int sp, rd, bp, ig;
        case (mode)
            0:       begin sp = 100; rd = 100; bp = 0;  ig = 0;  end
            1:       begin sp = 40;  rd = 60;  bp = 15; ig = 15; end
            2:       begin sp = 60;  rd = 80;  bp = 70; ig = 5;  end
            default: begin sp = 30;  rd = 30;  bp = 10; ig = 40; end
        endcase
        for (int r = 0; r < N; r++)
            if (!pend[r] && $urandom_range(0, 99) < sp) spawn(r);
        apply_reqs();
        bus.rsp_ready_i = $urandom_range(0, 99) < rd;
        pres_l  = 1'($urandom_range(0, 1));
        pres_r  = 1'($urandom_range(0, 1));
        id_err  = 1'($urandom_range(0, 1));
        sig_err = 1'($urandom_range(0, 1));
        sd_in   = SDW'($urandom_range(0, (1 << SDW) - 1));
        byp_l   = $urandom_range(0, 99) < bp;
        byp_r   = $urandom_range(0, 99) < bp;
        ign_l   = $urandom_range(0, 99) < ig;
        ign_r   = $urandom_range(0, 99) < ig;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_zero("mid_rst");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        for (int r = 0; r < N; r++) spawn(r);
        apply_reqs();
        bus.rsp_ready_i = 1'b1;
        {pres_l, pres_r, id_err, sig_err} = '0;
        {byp_l, byp_r, ign_l, ign_r} = '0;
        sd_in = '0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 2400; cyc++) begin
            if (cyc == 820 || cyc == 1730) do_reset();
            check_outputs();
            drive((cyc / 150) % 4);
            #1;
            chk("req_ready", bus.req_ready_o, exp_ready());
            if (cyc == 0) chk("first_grant", bus.req_ready_o, 1);
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
